// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte sources.
// Round-robin grant, one-byte holding register, registered outputs.
// Optional macro ARB_PKT_LOCK_EN: hold the grant for a whole packet
// (up to the req_last byte) with a mid-packet idle timeout of TMO cycles.
// Without it every byte re-arbitrates, interleaving sources byte by byte.
module uart_tx_arbiter #(
    parameter int          N_REQ = 3,
    parameter int          DW    = 8,
    parameter logic [15:0] TMO   = 16'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_vld,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_rdy,
    output logic                vld_tx,
    output logic [DW-1:0]       d_tx,
    input  logic                rdy_tx,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [DW-1:0] sel_data;

`ifdef ARB_PKT_LOCK_EN
    logic [15:0]   cnt;
    logic          hold_last;
`else
    // req_last and TMO have no function when packets are not locked
    logic          unused_cfg;
    assign unused_cfg = ^{req_last, TMO};
`endif

    // Round-robin search: first requester above ptr, wrapping modulo N_REQ
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!pick_vld && req_vld[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // Byte offered by the current owner
    always_comb begin
        sel_data = req_data[int'(gidx)*DW +: DW];
    end

    // Arbitration FSM; all outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            req_rdy   <= '0;
            vld_tx    <= 1'b0;
            d_tx      <= '0;
            busy      <= 1'b0;
            ptr       <= PW'(N_REQ - 1);
            gidx      <= '0;
`ifdef ARB_PKT_LOCK_EN
            cnt       <= '0;
            hold_last <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt     <= N_REQ'(1) << pick_idx;
                        req_rdy <= N_REQ'(1) << pick_idx;
                        gidx    <= pick_idx;
                        busy    <= 1'b1;
                        state   <= LOAD;
`ifdef ARB_PKT_LOCK_EN
                        cnt     <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (req_vld[gidx]) begin
                        d_tx      <= sel_data;
                        req_rdy   <= '0;
                        vld_tx    <= 1'b1;
                        state     <= SEND;
`ifdef ARB_PKT_LOCK_EN
                        hold_last <= req_last[gidx];
                    end else if (TMO != 16'd0 && cnt == TMO - 16'd1) begin
                        // owner went quiet mid-packet: force release
                        gnt     <= '0;
                        req_rdy <= '0;
                        busy    <= 1'b0;
                        ptr     <= gidx;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
`endif
                    end
                end
                SEND: begin
                    if (rdy_tx) begin
                        vld_tx <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
                        if (hold_last) begin
                            gnt     <= '0;
                            busy    <= 1'b0;
                            ptr     <= gidx;
                            state   <= IDLE;
                        end else begin
                            cnt     <= '0;
                            req_rdy <= gnt;
                            state   <= LOAD;
                        end
`else
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= gidx;
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    req_rdy <= '0;
                    vld_tx  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte sources,
// a transmitter model with configurable ready pattern, and a scoreboard
// of expected transmitted bytes in order.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld  = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_rdy;
    logic            vld_tx;
    logic [DW-1:0]   d_tx;
    logic            rdy_tx = 1'b0;
    logic [N-1:0]    gnt;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .TMO(16'd20)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
        .req_last(req_last), .req_rdy(req_rdy), .vld_tx(vld_tx), .d_tx(d_tx),
        .rdy_tx(rdy_tx), .gnt(gnt), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sb[$];
    int          xfer_cnt = 0;
    logic [8:0]  src_mem [N][16];
    int          src_wr [N];
    int          src_rd [N];
    int          rdy_period = 1;
    int          rdy_ph = 0;
    logic [N-1:0] acc;

    // source + transmitter model: handshake sampled at negedge, applied after posedge
    initial begin
        forever begin
            @(negedge clk);
            acc = req_vld & req_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i]) begin
                    req_vld[i]             = 1'b1;
                    req_data[i*DW +: DW]   = src_mem[i][src_rd[i]][7:0];
                    req_last[i]            = src_mem[i][src_rd[i]][8];
                end else begin
                    req_vld[i] = 1'b0;
                end
            end
            if (rdy_period == 0) rdy_tx = 1'b0;
            else if (rdy_period == 1) rdy_tx = 1'b1;
            else begin
                rdy_tx = (rdy_ph == 0);
                rdy_ph = (rdy_ph + 1) % rdy_period;
            end
        end
    end

    // scoreboard: every transfer must match the next expected byte
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (!rst && vld_tx && rdy_tx) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL xfer_unexpected got=%h expected=none", d_tx);
                end else begin
                    exp_b = sb.pop_front();
                    if (d_tx !== exp_b) begin
                        failures++;
                        $display("FAIL xfer_data got=%h expected=%h", d_tx, exp_b);
                    end
                end
                xfer_cnt++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic submit(input int id, input logic [7:0] data, input logic last);
        src_mem[id][src_wr[id]] = {last, data};
        src_wr[id]++;
    endtask

    task automatic clear_src;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        sb.delete();
    endtask

    task automatic do_reset;
        @(posedge clk);
        #3 rst = 1'b1;
        clear_src();
        rdy_period = 1;
        repeat (2) @(negedge clk);
        clear_src();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !vld_tx) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain got=pending(%0d) expected=0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        submit(0, 8'h10, 1'b1);
        submit(1, 8'h11, 1'b1);
        submit(2, 8'h12, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (vld_tx !== 1'b0) begin failures++; $display("FAIL rst_vld_tx got=%b expected=0", vld_tx); end
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b expected=000", gnt); end
        checks++; if (req_rdy !== 3'b000) begin failures++; $display("FAIL rst_req_rdy got=%b expected=000", req_rdy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b expected=0", busy); end
        checks++; if (d_tx !== 8'h00) begin failures++; $display("FAIL rst_d_tx got=%h expected=00", d_tx); end
        sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
        rdy_period = 1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rst_first_gnt got=%b expected=001", gnt); end
        checks++; if (req_rdy !== 3'b001) begin failures++; $display("FAIL rst_first_rdy got=%b expected=001", req_rdy); end
        wait_drain("reset");
    endtask

    task automatic test_frame;
        int base, bad = 0;
        bit done = 0;
        do_reset();
        base = xfer_cnt;
        rdy_period = 10;
        submit(1, 8'h41, 1'b0); submit(1, 8'h42, 1'b0); submit(1, 8'h43, 1'b1);
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
        for (int g = 0; g < 500; g++) begin
            @(negedge clk);
            if (vld_tx && gnt !== 3'b010) bad++;
            if (g > 2 && sb.size() == 0 && !busy) begin done = 1; break; end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL frame_gnt got=%0d_bad_cycles expected=0", bad); end
        checks++; if (!done) begin failures++; $display("FAIL frame_drain got=pending(%0d) expected=0", sb.size()); end
        checks++; if (xfer_cnt - base != 3) begin failures++; $display("FAIL frame_count got=%0d expected=3", xfer_cnt - base); end
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL frame_idle_gnt got=%b expected=000", gnt); end
        rdy_period = 1;
    endtask

    task automatic test_contention;
        bit seen = 0;
        do_reset();
        submit(0, 8'hA0, 1'b0); submit(0, 8'hA1, 1'b1);
        submit(2, 8'hC0, 1'b0); submit(2, 8'hC1, 1'b1);
`ifdef ARB_PKT_LOCK_EN
        sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hC0); sb.push_back(8'hC1);
`else
        sb.push_back(8'hA0); sb.push_back(8'hC0); sb.push_back(8'hA1); sb.push_back(8'hC1);
`endif
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (gnt != 3'b000) begin seen = 1; break; end
        end
        checks++;
        if (!seen || gnt !== 3'b001) begin failures++; $display("FAIL cont_first_gnt got=%b expected=001", gnt); end
        wait_drain("contention");
    endtask

    task automatic test_timeout;
        int base, n = 0, exp_n;
        bit seen = 0;
        do_reset();
        base = xfer_cnt;
        submit(0, 8'h30, 1'b0);
        submit(1, 8'h31, 1'b1);
        sb.push_back(8'h30); sb.push_back(8'h31);
        for (int g = 0; g < 100; g++) begin
            @(posedge clk);
            #2;
            if (xfer_cnt >= base + 1) begin seen = 1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL tmo_first_xfer got=none expected=1"); end
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (gnt == 3'b001) n++;
            else break;
        end
`ifdef ARB_PKT_LOCK_EN
        exp_n = 20;
`else
        exp_n = 0;
`endif
        checks++; if (n != exp_n) begin failures++; $display("FAIL tmo_load_cycles got=%0d expected=%0d", n, exp_n); end
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL tmo_release got=%b expected=000", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL tmo_next_gnt got=%b expected=010", gnt); end
        wait_drain("timeout");
    endtask

    task automatic test_stall;
        int base, bad = 0;
        bit seen = 0;
        do_reset();
        rdy_period = 0;
        base = xfer_cnt;
        submit(0, 8'h55, 1'b1);
        sb.push_back(8'h55);
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (vld_tx) begin seen = 1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall_vld got=0 expected=1"); end
        for (int g = 0; g < 500; g++) begin
            @(negedge clk);
            if (!(vld_tx === 1'b1 && d_tx === 8'h55)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d_bad_cycles expected=0", bad); end
        checks++; if (xfer_cnt != base) begin failures++; $display("FAIL stall_no_xfer got=%0d expected=0", xfer_cnt - base); end
        rdy_period = 1;
        @(negedge clk);
        checks++; if (vld_tx !== 1'b1 || rdy_tx !== 1'b1) begin failures++; $display("FAIL stall_pre_xfer got=vld%b_rdy%b expected=vld1_rdy1", vld_tx, rdy_tx); end
        @(negedge clk);
        checks++; if (vld_tx !== 1'b0) begin failures++; $display("FAIL stall_vld_drop got=%b expected=0", vld_tx); end
        wait_drain("stall");
    endtask

    task automatic test_reset_mid;
        int base;
        bit seen = 0;
        do_reset();
        base = xfer_cnt;
        submit(1, 8'h61, 1'b0); submit(1, 8'h62, 1'b0); submit(1, 8'h63, 1'b1);
        sb.push_back(8'h61);
        for (int g = 0; g < 100; g++) begin
            @(posedge clk);
            #2;
            if (xfer_cnt >= base + 1) begin seen = 1; break; end
        end
        @(negedge clk);
        rdy_period = 0;
        seen = 0;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (vld_tx && d_tx == 8'h62) begin seen = 1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_byte2 got=%h expected=62", d_tx); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (vld_tx !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b expected=0", vld_tx); end
        checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt got=%b/%b expected=000/0", gnt, busy); end
        checks++; if (d_tx !== 8'h00 || req_rdy !== 3'b000) begin failures++; $display("FAIL mid_rst_out got=%h/%b expected=00/000", d_tx, req_rdy); end
        clear_src();
        repeat (2) @(negedge clk);
        clear_src();
        rdy_period = 1;
        rst = 1'b0;
        submit(2, 8'h71, 1'b1);
        sb.push_back(8'h71);
        seen = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (gnt != 3'b000) begin seen = 1; break; end
        end
        checks++; if (!seen || gnt !== 3'b100) begin failures++; $display("FAIL mid_fresh_gnt got=%b expected=100", gnt); end
        wait_drain("reset_mid");
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        test_reset();
        test_frame();
        test_contention();
        test_timeout();
        test_stall();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter of the serial debug unit between several byte sources: command echo, debug response formatter, status reporter. Arbitrates round-robin at packet granularity and buffers one byte. It drives the transmitter's `vld_tx`/`d_tx` and obeys its `rdy_tx` handshake. A lock timeout keeps a stalled source from starving the others.

## Interface
- `N_REQ`, 3, number of requesters, legal 2..8
- `DW`, 8, byte width
- `TMO`, 16'd1000, mid-packet idle cycles before forced release; 0 = never release
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_vld`  in  N_REQ  requester i has a byte on its `req_data` slice
- `req_data`  in  N_REQ*DW  byte of requester i in bits [i*DW +: DW]
- `req_last`  in  N_REQ  byte of requester i ends its packet
- `req_rdy`  out  N_REQ  byte of requester i accepted this cycle when `req_vld[i]` is also high
- `vld_tx`  out  1  byte valid to transmitter
- `d_tx`  out  DW  byte to transmitter
- `rdy_tx`  in  1  transmitter ready; transfer when `vld_tx && rdy_tx`
- `gnt`  out  N_REQ  one-hot current owner; all-zero when idle
- `busy`  out  1  state != IDLE

## Operation
- Requester rule: once `req_vld[i]` is high, it stays high with stable data and last until `req_rdy[i]`. It may go low between bytes of a packet.
- States: IDLE, LOAD, SEND.
- IDLE:
  - If any `req_vld`, grant the first set bit searching upward from `ptr+1` modulo N_REQ.
  - Register `gnt`, clear the timeout counter, go to LOAD.
- LOAD:
  - `req_rdy = gnt` and is zero in every other state.
  - On `req_vld[g]`: capture data into `hold`, `req_last` into `hold_last`, go to SEND.
  - Otherwise increment the timeout counter. When it reaches TMO (TMO≠0), clear `gnt`, set `ptr = g`, go to IDLE.
- SEND:
  - `vld_tx = 1`, `d_tx = hold`.
  - On transfer with `hold_last` set: set `ptr = g`, clear `gnt`, go to IDLE.
  - On transfer with `hold_last` clear: clear the counter, go to LOAD.
- `ptr` resets to N_REQ-1, so requester 0 wins the first contention.
- Requests from non-granted sources are ignored until release; no preemption.

## Timing
- Reset values: state IDLE; `gnt`=0; `req_rdy`=0; `vld_tx`=0; `d_tx`=0; `busy`=0; `ptr`=N_REQ-1; counter=0; `hold_last`=0.
- All outputs are registered or decoded from registered state only; no combinational path from `rdy_tx` or `req_vld` to any output.
- Latency:
  - `req_vld` rising in IDLE → `gnt` the next cycle.
  - `req_rdy` asserted in that same cycle.
  - `vld_tx` asserted the cycle after acceptance.
  - Best case 3 cycles per byte, far below one UART frame.
- `vld_tx` and `d_tx` hold stable from the SEND entry until the transfer cycle, then `vld_tx` drops the next cycle.
- `rdy_tx` low for a whole frame simply stalls SEND; the duration is unbounded.
- Simultaneous requests: only the round-robin winner is granted; the others keep `req_vld` high and are served in ptr order.
- A single-byte packet (`req_last` on its first byte) releases after one transfer.
- Timeout only counts in LOAD, never in SEND.
- Reset mid-packet: the packet is dropped and outputs return to reset values immediately. The transmitter shares `rst`, so no half-handshake survives.

## Configuration
- `ARB_PKT_LOCK_EN` defined:
  - Grant is held from first byte to the `req_last` byte, as described above.
  - The timeout applies.
- Undefined:
  - `req_last` is ignored and every transfer releases to IDLE with `ptr` updated, giving byte-level round-robin interleaving.
  - The timeout logic is not built; the counter stays 0.

## Test plan
- Reset with all `req_vld` high → `vld_tx`=0, `gnt`=0, `req_rdy`=0 during reset. After deassert, `gnt`=3'b001 on the first edge.
- Req1 sends 0x41,0x42,0x43 (last on 0x43), `rdy_tx` pulses once per frame → `d_tx` sequence 0x41,0x42,0x43, `gnt`=3'b010 throughout, then IDLE.
- Req0 and req2 both sending 2-byte packets at once after reset:
  - With `ARB_PKT_LOCK_EN`: order is req0's both bytes, then req2's both bytes.
  - Without it: order alternates req0, req2, req0, req2.
- Req0 sends 1 non-last byte then drops `req_vld` while req1 waits, TMO=20 → `gnt` goes from 3'b001 to 0 after 20 LOAD cycles, then to 3'b010.
- Hold `rdy_tx`=0 for 500 cycles with a byte in SEND → `vld_tx`=1 and `d_tx` stable for the full 500 cycles; the transfer occurs on the first `rdy_tx`=1 edge.
- Assert `rst` during SEND of byte 2 of 3 → `vld_tx` low immediately; after release the next grant starts a fresh packet.
